// File: rtl/bomb_ctrl.sv
// Bomb fuse/blast controller: arms on a key edge, burns a three-step fuse, then flags wall breaks and blast deaths.
// Optional feature macro: BOMB_CTRL_DEATH_EN (enables the blast-radius death flag; otherwise death is tied to 0).
module bomb_ctrl #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned BOMB_SIZE  = 10,
  parameter int unsigned BREAK_DIST = 20,
  parameter int unsigned WALL_L     = 215,
  parameter int unsigned WALL_R     = 250,
  parameter int unsigned WALL_U     = 125,
  parameter int unsigned WALL_D     = 250,
  parameter int unsigned BLAST_R    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       level_load,
  input  logic       f_key,
  input  logic [9:0] char_pos_x,
  input  logic [9:0] char_pos_y,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic [3:0] b_cnt,
  output logic       busy,
  output logic       explode,
  output logic       b_wall_1_f,
  output logic       death
);

  localparam int unsigned PW = 10;
  localparam int unsigned SW = 11;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic signed [SW-1:0] S_SIZE  = SW'(BOMB_SIZE);
  localparam logic signed [SW-1:0] S_BREAK = SW'(BREAK_DIST);
  localparam logic signed [SW-1:0] S_WL    = SW'(WALL_L);
  localparam logic signed [SW-1:0] S_WR    = SW'(WALL_R);
  localparam logic signed [SW-1:0] S_WU    = SW'(WALL_U);
  localparam logic signed [SW-1:0] S_WD    = SW'(WALL_D);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FUSE  = 2'd1;
  localparam logic [1:0] BLAST = 2'd2;

  // Geometry parameters must fit the signed 11-bit gap arithmetic.
  if (BLAST_R > 1023 || BOMB_SIZE > 1023 || BREAK_DIST > 1023) begin : g_param_range
    $error("bomb_ctrl: geometry parameter out of range");
  end

  logic [1:0]    state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic          f_prev;
  logic [3:0]    cnt_nx;
  logic [PW-1:0] pos_x_nx, pos_y_nx;
  logic          explode_nx;
  logic          wall_nx;
  logic          key_rise, tick_term;

  logic signed [SW-1:0] bx, by, box_l, box_r, gap;
  logic                 wall_hit;

  assign key_rise  = f_key & ~f_prev;
  assign tick_term = (tick == TICK_LAST);

  // Horizontal gap between the bomb box and the wall box, zero when overlapping.
  always_comb begin
    bx    = signed'(SW'(bomb_pos_x));
    by    = signed'(SW'(bomb_pos_y));
    box_l = bx - S_SIZE;
    box_r = bx + S_SIZE;
    gap   = '0;
    if (box_r < S_WL) begin
      gap = S_WL - box_r;
    end else if (box_l > S_WR) begin
      gap = box_l - S_WR;
    end
    wall_hit = (by >= S_WU) && (by <= S_WD) && (gap < S_BREAK);
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = b_cnt;
    tick_nx    = tick;
    pos_x_nx   = bomb_pos_x;
    pos_y_nx   = bomb_pos_y;
    explode_nx = 1'b0;
    if (!active) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
      tick_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_rise) begin
            state_nx = FUSE;
            cnt_nx   = 4'd1;
            tick_nx  = '0;
            pos_x_nx = char_pos_x;
            pos_y_nx = char_pos_y;
          end
        end
        FUSE: begin
          if (tick_term) begin
            tick_nx = '0;
            if (b_cnt >= 4'd2) begin
              state_nx   = BLAST;
              cnt_nx     = 4'd3;
              explode_nx = 1'b1;
            end else begin
              cnt_nx = b_cnt + 4'd1;
            end
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        BLAST: begin
          if (tick_term) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
            tick_nx  = '0;
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
          tick_nx  = '0;
        end
      endcase
    end
    // A set in the explode cycle wins over a coincident level_load clear.
    wall_nx = b_wall_1_f;
    if (explode_nx && wall_hit) begin
      wall_nx = 1'b1;
    end else if (level_load) begin
      wall_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      f_prev     <= 1'b0;
      b_cnt      <= 4'd0;
      busy       <= 1'b0;
      explode    <= 1'b0;
      bomb_pos_x <= '0;
      bomb_pos_y <= '0;
      b_wall_1_f <= 1'b0;
    end else begin
      state      <= state_nx;
      tick       <= tick_nx;
      f_prev     <= f_key;
      b_cnt      <= cnt_nx;
      busy       <= (cnt_nx != 4'd0);
      explode    <= explode_nx;
      bomb_pos_x <= pos_x_nx;
      bomb_pos_y <= pos_y_nx;
      b_wall_1_f <= wall_nx;
    end
  end

`ifdef BOMB_CTRL_DEATH_EN
  localparam logic signed [SW-1:0] S_BLAST = SW'(BLAST_R);

  logic signed [SW-1:0] dx, dy, adx, ady;
  logic                 death_hit;
  logic                 death_nx;

  // Character is caught when inside the blast square around the bomb.
  always_comb begin
    dx        = signed'(SW'(char_pos_x)) - bx;
    dy        = signed'(SW'(char_pos_y)) - by;
    adx       = (dx < 0) ? -dx : dx;
    ady       = (dy < 0) ? -dy : dy;
    death_hit = (adx < S_BLAST) && (ady < S_BLAST);
    death_nx  = death;
    if (explode_nx && death_hit) begin
      death_nx = 1'b1;
    end else if (level_load) begin
      death_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      death <= 1'b0;
    end else begin
      death <= death_nx;
    end
  end
`else
  assign death = 1'b0;
`endif

endmodule

// File: tb/tb_bomb_ctrl.sv
// Self-checking bench for bomb_ctrl: directed scenarios plus random stimulus against a fuse-age reference model.
module tb_bomb_ctrl;

  localparam int TD = 4;
`ifdef BOMB_CTRL_DEATH_EN
  localparam int DEATH_ON = 1;
`else
  localparam int DEATH_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, active, level_load, f_key;
  logic [9:0] char_pos_x, char_pos_y;
  logic [9:0] bomb_pos_x, bomb_pos_y;
  logic [3:0] b_cnt;
  logic       busy, explode, b_wall_1_f, death;

  int ntests = 0;
  int nfail  = 0;

  bomb_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .active(active), .level_load(level_load), .f_key(f_key),
    .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .bomb_pos_x(bomb_pos_x), .bomb_pos_y(bomb_pos_y),
    .b_cnt(b_cnt), .busy(busy), .explode(explode),
    .b_wall_1_f(b_wall_1_f), .death(death)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bomb is an age in cycles since arming; fuse count follows from age.
  int m_age = -1;
  int m_px = 0, m_py = 0;
  int m_exp = 0, m_wall = 0, m_death = 0, m_prev = 0;
  bit started = 0;

  function automatic int wall_rule(input int px, input int py);
    int l, r, g;
    l = px - 10;
    r = px + 10;
    if (r < 215) g = 215 - r;
    else if (l > 250) g = l - 250;
    else g = 0;
    return (py >= 125 && py <= 250 && g < 20) ? 1 : 0;
  endfunction

  function automatic int death_rule(input int cx, input int cy, input int px, input int py);
    int ax, ay;
    ax = (cx > px) ? cx - px : px - cx;
    ay = (cy > py) ? cy - py : py - cy;
    return (DEATH_ON != 0 && ax < 30 && ay < 30) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_age = -1; m_px = 0; m_py = 0; m_exp = 0;
      m_wall = 0; m_death = 0; m_prev = 0; started = 1;
    end else begin
      int hw, hd;
      hw = 0; hd = 0; m_exp = 0;
      if (!active) begin
        m_age = -1;
      end else if (m_age < 0) begin
        if (f_key && m_prev == 0) begin
          m_age = 0; m_px = int'(char_pos_x); m_py = int'(char_pos_y);
        end
      end else begin
        m_age++;
        if (m_age == 2 * TD) begin
          m_exp = 1;
          hw = wall_rule(m_px, m_py);
          hd = death_rule(int'(char_pos_x), int'(char_pos_y), m_px, m_py);
        end else if (m_age == 3 * TD) begin
          m_age = -1;
        end
      end
      if (hw != 0) m_wall = 1; else if (level_load) m_wall = 0;
      if (hd != 0) m_death = 1; else if (level_load) m_death = 0;
      m_prev = f_key ? 1 : 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      int mc;
      mc = (m_age < 0) ? 0 : 1 + m_age / TD;
      chk("bomb_pos_x", int'(bomb_pos_x), m_px);
      chk("bomb_pos_y", int'(bomb_pos_y), m_py);
      chk("b_cnt", int'(b_cnt), mc);
      chk("busy", int'(busy), (mc != 0) ? 1 : 0);
      chk("explode", int'(explode), m_exp);
      chk("b_wall_1_f", int'(b_wall_1_f), m_wall);
      chk("death", int'(death), m_death);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Arm at (bx,by), press again mid-fuse, hold char at (cx,cy) for the explode edge.
  task automatic run_bomb(input int bx, input int by, input int cx, input int cy,
                          input bit ll, input int ew, input int ed);
    char_pos_x = 10'(bx); char_pos_y = 10'(by); f_key = 1'b1;
    cyc(1);
    f_key = 1'b0;
    chk("arm_pos_x", int'(bomb_pos_x), bx);
    chk("arm_pos_y", int'(bomb_pos_y), by);
    chk("arm_cnt", int'(b_cnt), 1);
    char_pos_x = 10'(cx); char_pos_y = 10'(cy);
    cyc(2);
    f_key = 1'b1;
    cyc(1);
    f_key = 1'b0;
    cyc(2);
    chk("step_cnt", int'(b_cnt), 2);
    cyc(2);
    level_load = ll;
    cyc(1);
    level_load = 1'b0;
    chk("boom_explode", int'(explode), 1);
    chk("boom_cnt", int'(b_cnt), 3);
    chk("boom_pos_x", int'(bomb_pos_x), bx);
    chk("boom_wall", int'(b_wall_1_f), ew);
    chk("boom_death", int'(death), ed);
    cyc(1);
    chk("post_explode", int'(explode), 0);
    cyc(3);
    chk("done_cnt", int'(b_cnt), 0);
    cyc(2);
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; level_load = 1'b0; f_key = 1'b0;
    char_pos_x = '0; char_pos_y = '0;
    cyc(2);
    reset = 1'b0;
    chk("rst_cnt", int'(b_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pos", int'(bomb_pos_x), 0);
    active = 1'b1;
    cyc(2);

    run_bomb(232, 300, 100, 100, 1'b0, 0, 0);
    run_bomb(200, 180, 0, 0, 1'b0, 1, 0);
    level_load = 1'b1; cyc(1); level_load = 1'b0;
    chk("ll_wall", int'(b_wall_1_f), 0);
    run_bomb(150, 180, 0, 0, 1'b0, 0, 0);
    run_bomb(200, 300, 0, 0, 1'b0, 0, 0);
    run_bomb(300, 300, 310, 310, 1'b0, 0, DEATH_ON);
    level_load = 1'b1; cyc(1); level_load = 1'b0;
    chk("ll_death", int'(death), 0);
    run_bomb(300, 300, 340, 300, 1'b0, 0, 0);
    run_bomb(200, 180, 0, 0, 1'b1, 1, 0);

    // Abort at fuse count 2: wall flag must survive.
    char_pos_x = 10'd100; char_pos_y = 10'd100; f_key = 1'b1;
    cyc(1); f_key = 1'b0;
    cyc(4);
    chk("abort_pre", int'(b_cnt), 2);
    active = 1'b0;
    cyc(1);
    chk("abort_cnt", int'(b_cnt), 0);
    chk("abort_explode", int'(explode), 0);
    chk("abort_wall", int'(b_wall_1_f), 1);
    active = 1'b1;
    cyc(2);

    // Key held across the whole bomb and into idle must not re-arm.
    f_key = 1'b1;
    cyc(3 * TD + 6);
    chk("held_no_rearm", int'(b_cnt), 0);
    f_key = 1'b0;
    cyc(2);

    // Reset mid-fuse aborts without explode.
    f_key = 1'b1; cyc(1); f_key = 1'b0;
    cyc(6);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("rst_mid_cnt", int'(b_cnt), 0);
    chk("rst_mid_explode", int'(explode), 0);
    chk("rst_mid_wall", int'(b_wall_1_f), 0);
    cyc(2);

    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      active     = ($urandom_range(0, 59) != 0);
      level_load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) f_key = ~f_key;
      if ($urandom_range(0, 1) == 0) begin
        char_pos_x = 10'($urandom_range(0, 639));
        char_pos_y = 10'($urandom_range(0, 479));
      end else begin
        char_pos_x = 10'($urandom_range(150, 330));
        char_pos_y = 10'($urandom_range(110, 330));
      end
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clock cycles per fuse step.
REQ-002 SHALL have parameter BOMB_SIZE, default 10: bomb half-width in pixels.
REQ-003 SHALL have parameter BREAK_DIST, default 20: maximum bomb-to-wall gap, in pixels, that breaks the wall.
REQ-004 SHALL have parameters WALL_L/WALL_R/WALL_U/WALL_D, defaults 215/250/125/250: breakable wall box.
REQ-005 SHALL have parameter BLAST_R, default 30: death radius per axis, in pixels.
REQ-006 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-007 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: active  in  1  level is running; low aborts the bomb.
REQ-009 SHALL have ports: level_load  in  1  one-cycle pulse that clears the sticky flags.
REQ-010 SHALL have ports: f_key  in  1  bomb button, active-high level.
REQ-011 SHALL have ports: char_pos_x, char_pos_y  in  10 each  character centre.
REQ-012 SHALL have ports: bomb_pos_x, bomb_pos_y  out  10 each  latched bomb centre.
REQ-013 SHALL have ports: b_cnt  out  4  fuse count (0 = no bomb, 1..2 = burning, 3 = exploding).
REQ-014 SHALL have ports: busy  out  1  b_cnt != 0.
REQ-015 SHALL have ports: explode  out  1  one-cycle pulse when b_cnt enters 3.
REQ-016 SHALL have ports: b_wall_1_f  out  1  sticky flag: wall broken.
REQ-017 SHALL have ports: death  out  1  sticky flag: character caught in blast.

Function
REQ-018 SHALL use an FSM with states IDLE, FUSE, BLAST.
REQ-019 SHALL detect f_key rising edges with a one-register edge detector.
REQ-020 IDLE->FUSE on an f_key rising edge while active=1: latch char_pos into bomb_pos, b_cnt=1, clear the tick counter.
REQ-021 SHALL count ticks 0..TICK_DIV-1; at terminal count, wrap to 0 and advance the fuse one step.
REQ-022 FUSE: each fuse step increments b_cnt; on the step 2->3, enter BLAST and pulse explode for exactly that cycle.
REQ-023 BLAST: after one full tick period, go to IDLE with b_cnt=0; bomb_pos holds its last value.
REQ-024 SHALL ignore f_key edges in FUSE and BLAST (one bomb at a time); a key held from before arming SHALL NOT re-arm.
REQ-025 active=0 in any state SHALL force IDLE next cycle with b_cnt=0 and no explode pulse; the sticky flags are unaffected.
REQ-026 In the explode cycle, SHALL set b_wall_1_f if both hold:
- bomb_pos_y lies within [WALL_U, WALL_D];
- the horizontal gap between bomb box [x-BOMB_SIZE, x+BOMB_SIZE] and [WALL_L, WALL_R] is < BREAK_DIST (overlap counts as gap 0).
REQ-027 Gap arithmetic SHALL use 11-bit signed values so a bomb near x=0 or x=635 cannot wrap.
REQ-028 In the explode cycle, SHALL set death if |char_pos_x-bomb_pos_x| < BLAST_R and |char_pos_y-bomb_pos_y| < BLAST_R.
REQ-029 level_load SHALL clear b_wall_1_f and death; if coincident with explode, the set SHALL win.
REQ-030 All outputs SHALL be registered; b_cnt SHALL change in the cycle after the terminal tick.

Reset
REQ-031 reset SHALL take priority over all inputs.
REQ-032 Reset values: state IDLE, b_cnt 0, busy 0, explode 0, bomb_pos 0, b_wall_1_f 0, death 0, tick counter 0, edge register 0.
REQ-033 Reset mid-fuse SHALL abort with no explode pulse.

Configuration
REQ-034 Macro BOMB_CTRL_DEATH_EN defined: death SHALL be set per REQ-028.
REQ-035 Macro BOMB_CTRL_DEATH_EN undefined: death SHALL be tied to 0 and the blast-radius logic SHALL be absent.

Verification (TICK_DIV=4)
REQ-036 Reset, active=1, char=(232,300), f_key rising -> bomb_pos=(232,300); b_cnt 1,2,3 at 4-cycle steps; one explode pulse; b_cnt=0 four cycles after the pulse.
REQ-037 Bomb at (200,180), explode -> b_wall_1_f=1 (gap 5); bomb at (150,180) -> stays 0 (gap 55); bomb at (200,300) -> stays 0 (y out of range).
REQ-038 Second f_key press during FUSE -> ignored, bomb_pos unchanged, single explode; f_key held through IDLE -> no re-arm.
REQ-039 active dropped when b_cnt=2 -> b_cnt=0 next cycle, no explode, b_wall_1_f unchanged.
REQ-040 With the macro defined: char at bomb_pos+(10,10) at explode -> death=1; char at bomb_pos+(40,0) -> death=0. Without the macro -> death=0 in both cases.
REQ-041 level_load pulse -> b_wall_1_f=0 and death=0; level_load in the explode cycle with break conditions met -> b_wall_1_f=1.
